// File: rtl/riscv_defs.sv
// Shared pipeline definitions: bus widths, stall bit indices and the fetch FSM encoding.
package riscv_defs;

    localparam int unsigned STALL_BUS_W = 6;
    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

    localparam int unsigned STALL_PC = 0;
    localparam int unsigned STALL_IF = 1;

    typedef enum logic {
        FETCH = 1'b0,
        DONE  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: combinational lookup, single-word fill, valid bits cleared by reset only.
module if_icache
    import riscv_defs::*;
#(
    parameter int unsigned LINES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] lookup_pc,
    output logic                   hit_c,
    output logic [INST_W-1:0]      rdata_c,
    input  logic                   fill_en,
    input  logic [INST_ADDR_W-1:0] fill_pc,
    input  logic [INST_W-1:0]      fill_data
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = INST_ADDR_W - IDX_W - 2;

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [INST_W-1:0] data_q [LINES];
    logic [IDX_W-1:0]  lk_idx, fl_idx;
    logic [TAG_W-1:0]  lk_tag, fl_tag;
    logic [3:0]        unused_lo;

    assign lk_idx    = lookup_pc[IDX_W+1:2];
    assign lk_tag    = lookup_pc[INST_ADDR_W-1:IDX_W+2];
    assign fl_idx    = fill_pc[IDX_W+1:2];
    assign fl_tag    = fill_pc[INST_ADDR_W-1:IDX_W+2];
    assign unused_lo = {lookup_pc[1:0], fill_pc[1:0]};

    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[fl_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data storage needs no reset; valid_q qualifies every read.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fl_idx]  <= fl_tag;
            data_q[fl_idx] <= fill_data;
        end
    end

    assign hit_c   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign rdata_c = data_q[lk_idx];

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads on the shared memory port.
// Optional direct-mapped icache enabled with `define IF_ICACHE_EN.
module if_fetch
    import riscv_defs::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
`ifdef IF_ICACHE_EN
    ,
    parameter int unsigned ICACHE_LINES = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_BUS_W-1:0] stall,
    input  logic                   ex_jmp_wrong_i,
    input  logic [INST_ADDR_W-1:0] ex_jmp_target_i,
    input  logic                   mem_gnt_i,
    input  logic [7:0]             mem_din_i,
    output logic                   mem_rd_o,
    output logic [INST_ADDR_W-1:0] mem_a_o,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
    output logic                   stall_req_o
);

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [INST_W-1:0]      if_inst_q, if_inst_d;
    logic [2:0]             issue_q, issue_d;
    logic [1:0]             recv_q, recv_d;
    logic                   pend_q, pend_d;
    logic                   drop_q, drop_d;
    logic [23:0]            buf_q, buf_d;
    logic                   first_c, hit_c, req_c, gnt_c, fill_c;
    logic [INST_W-1:0]      hit_data_c;
    logic [STALL_BUS_W-3:0] unused_stall;

    assign unused_stall = stall[STALL_BUS_W-1:2];

    assign first_c = (state_q == FETCH) && (issue_q == 3'd0) && (recv_q == 2'd0) && !pend_q;

`ifdef IF_ICACHE_EN
    logic lookup_hit_c;

    if_icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .lookup_pc(pc_q),
        .hit_c    (lookup_hit_c),
        .rdata_c  (hit_data_c),
        .fill_en  (fill_c),
        .fill_pc  (pc_q),
        .fill_data({mem_din_i, buf_q})
    );

    assign hit_c = first_c && lookup_hit_c;
`else
    logic unused_cache;

    assign hit_c        = 1'b0;
    assign hit_data_c   = ZERO_WORD;
    assign unused_cache = fill_c ^ first_c;
`endif

    // Request path is combinational so the first byte is asked for in the first FETCH cycle.
    assign req_c       = (state_q == FETCH) && (issue_q < 3'd4) && !hit_c;
    assign gnt_c       = req_c && mem_gnt_i;
    assign mem_rd_o    = rst && req_c;
    assign mem_a_o     = rst ? (pc_q + INST_ADDR_W'(issue_q)) : '0;
    assign stall_req_o = (state_q == FETCH);
    assign if_pc       = if_pc_q;
    assign if_inst     = if_inst_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;
        issue_d   = issue_q;
        recv_d    = recv_q;
        buf_d     = buf_q;
        pend_d    = 1'b0;
        drop_d    = 1'b0;
        fill_c    = 1'b0;

        if (ex_jmp_wrong_i) begin
            // Flush wins over everything; a byte granted now must be discarded when it returns.
            state_d = FETCH;
            pc_d    = ex_jmp_target_i;
            issue_d = 3'd0;
            recv_d  = 2'd0;
            drop_d  = gnt_c;
        end else if (state_q == FETCH) begin
            pend_d = gnt_c;
            if (gnt_c) begin
                issue_d = issue_q + 3'd1;
            end
            if (hit_c) begin
                state_d   = DONE;
                if_pc_d   = pc_q;
                if_inst_d = hit_data_c;
            end else if (pend_q && !drop_q) begin
                case (recv_q)
                    2'd0:    buf_d[7:0]   = mem_din_i;
                    2'd1:    buf_d[15:8]  = mem_din_i;
                    2'd2:    buf_d[23:16] = mem_din_i;
                    default: begin
                        state_d   = DONE;
                        if_pc_d   = pc_q;
                        if_inst_d = {mem_din_i, buf_q};
                        fill_c    = 1'b1;
                    end
                endcase
                if (recv_q != 2'd3) begin
                    recv_d = recv_q + 2'd1;
                end
            end
        end else if (!stall[STALL_IF] && !stall[STALL_PC]) begin
            state_d = FETCH;
            pc_d    = pc_q + 32'd4;
            issue_d = 3'd0;
            recv_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            if_pc_q   <= '0;
            if_inst_q <= '0;
            issue_q   <= 3'd0;
            recv_q    <= 2'd0;
            pend_q    <= 1'b0;
            drop_q    <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
            issue_q   <= issue_d;
            recv_q    <= recv_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
            buf_q     <= buf_d;
        end
    end

endmodule
